// File: rtl/riscv_pkg.sv
// Shared types for the writeback stage: register index, data word and FIFO entry.
package riscv_pkg;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] xlen_t;

  typedef struct packed {
    reg_idx_t rd;
    xlen_t    wd;
  } wb_entry_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/riscv_writeback_if.sv
// Writeback stage bus: pipeline/issue/long-latency inputs, regfile write port and hazard status.
interface riscv_writeback_if;
  import riscv_pkg::*;

  logic     pipe_valid_in;
  reg_idx_t pipe_rd_in;
  xlen_t    pipe_wd_in;
  logic     issue_valid_in;
  reg_idx_t issue_rd_in;
  logic     ll_valid_in;
  logic     ll_ready_out;
  reg_idx_t ll_rd_in;
  xlen_t    ll_wd_in;
  logic     write_enable_out;
  reg_idx_t rd_out;
  xlen_t    wd_out;
  logic [31:0] busy_out;
  logic     protocol_err_out;

  modport master (
    output pipe_valid_in, pipe_rd_in, pipe_wd_in,
    output issue_valid_in, issue_rd_in,
    output ll_valid_in, ll_rd_in, ll_wd_in,
    input  ll_ready_out, write_enable_out, rd_out, wd_out, busy_out, protocol_err_out
  );

  modport slave (
    input  pipe_valid_in, pipe_rd_in, pipe_wd_in,
    input  issue_valid_in, issue_rd_in,
    input  ll_valid_in, ll_rd_in, ll_wd_in,
    output ll_ready_out, write_enable_out, rd_out, wd_out, busy_out, protocol_err_out
  );

endinterface

// File: rtl/riscv_wb_fifo.sv
// Long-latency result FIFO; an accepted entry is poppable from the next cycle, no bypass.
// push_rdy is registered (count_next < DEPTH); simultaneous push and pop keep count steady.
module riscv_wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          push_vld,
  output logic          push_rdy,
  input  wb_entry_t     push_dat,
  input  logic          pop,
  output logic          empty,
  output wb_entry_t     head_dat,
  output logic [CW-1:0] count
);

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_next;
  logic          push_fire;

  assign push_fire  = push_vld && push_rdy;
  assign empty      = (count == '0);
  assign head_dat   = mem[rd_ptr];
  assign count_next = count + CW'(push_fire) - CW'(pop);

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      push_rdy <= 1'b0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + AW'(1);
      if (pop)       rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      push_rdy <= (count_next < CW'(DEPTH));
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_fire) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/riscv_writeback.sv
// Writeback arbiter: pipe results beat FIFO pops onto the registered regfile port (1 cycle).
// Pipe is never stalled; long-latency producers are throttled by ll_ready_out; busy_out tracks outstanding writes.
module riscv_writeback
  import riscv_pkg::*;
#(
  parameter int LL_DEPTH = 2
) (
  input logic              clk_in,
  input logic              rst_n_in,
  riscv_writeback_if.slave wb
);

  localparam int CW = $clog2(LL_DEPTH + 1);

  logic          pipe_take;
  logic          ll_push_vld;
  logic          ll_push_fire;
  logic          ll_rdy;
  logic          fifo_empty;
  logic          fifo_pop;
  wb_entry_t     fifo_head;
  wb_entry_t     ll_entry;
  logic [CW-1:0] ll_count;

  logic          we_q;
  reg_idx_t      rd_q;
  xlen_t         wd_q;
  logic [31:0]   busy_q;
  logic [31:0]   busy_nxt;
  logic          err_q;
  logic          err_hit;

  assign pipe_take    = wb.pipe_valid_in && (wb.pipe_rd_in != REG_ZERO);
  assign fifo_pop     = !pipe_take && !fifo_empty;
  assign ll_push_vld  = wb.ll_valid_in && (wb.ll_rd_in != REG_ZERO);
  assign ll_push_fire = ll_push_vld && ll_rdy;
  assign ll_entry     = '{rd: wb.ll_rd_in, wd: wb.ll_wd_in};

  riscv_wb_fifo #(.DEPTH(LL_DEPTH)) u_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .push_vld (ll_push_vld),
    .push_rdy (ll_rdy),
    .push_dat (ll_entry),
    .pop      (fifo_pop),
    .empty    (fifo_empty),
    .head_dat (fifo_head),
    .count    (ll_count)
  );

  // Set after clear so an issue to the register being retired keeps it busy.
  always_comb begin
    busy_nxt = busy_q;
    if (fifo_pop) busy_nxt[fifo_head.rd] = 1'b0;
    if (wb.issue_valid_in && (wb.issue_rd_in != REG_ZERO)) busy_nxt[wb.issue_rd_in] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    err_hit = 1'b0;
    if (wb.issue_valid_in && (wb.issue_rd_in != REG_ZERO) && busy_q[wb.issue_rd_in]) err_hit = 1'b1;
    if (pipe_take && busy_q[wb.pipe_rd_in]) err_hit = 1'b1;
    if (ll_push_fire && !busy_q[wb.ll_rd_in]) err_hit = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      we_q   <= 1'b0;
      rd_q   <= REG_ZERO;
      wd_q   <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (pipe_take) begin
        we_q <= 1'b1;
        rd_q <= wb.pipe_rd_in;
        wd_q <= wb.pipe_wd_in;
      end else if (fifo_pop) begin
        we_q <= 1'b1;
        rd_q <= fifo_head.rd;
        wd_q <= fifo_head.wd;
      end else begin
        we_q <= 1'b0;
      end
      busy_q <= busy_nxt;
      err_q  <= err_q | err_hit;
    end
  end

  assign wb.ll_ready_out     = ll_rdy;
  assign wb.write_enable_out = we_q;
  assign wb.rd_out           = rd_q;
  assign wb.wd_out           = wd_q;
  assign wb.busy_out         = busy_q;
  assign wb.protocol_err_out = err_q;

  a_count_bound: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    ll_count <= CW'(LL_DEPTH));

endmodule

// File: tb/tb_riscv_writeback.sv
// Directed bench for riscv_writeback: reset, pipe, long-latency, contention, same-cycle and error cases.
module tb_riscv_writeback;
  import riscv_pkg::*;

  logic clk_in;
  logic rst_n_in;
  int   n_tests;
  int   n_fail;

  riscv_writeback_if wb_if ();

  riscv_writeback #(.LL_DEPTH(2)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .wb       (wb_if)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_pipe(input logic v, input reg_idx_t rd, input xlen_t wd);
    wb_if.pipe_valid_in = v;
    wb_if.pipe_rd_in    = rd;
    wb_if.pipe_wd_in    = wd;
  endtask

  task automatic set_ll(input logic v, input reg_idx_t rd, input xlen_t wd);
    wb_if.ll_valid_in = v;
    wb_if.ll_rd_in    = rd;
    wb_if.ll_wd_in    = wd;
  endtask

  task automatic set_issue(input logic v, input reg_idx_t rd);
    wb_if.issue_valid_in = v;
    wb_if.issue_rd_in    = rd;
  endtask

  task automatic check_port(input string tag, input logic we, input reg_idx_t rd, input xlen_t wd);
    check({tag, ".we"}, 32'(wb_if.write_enable_out), 32'(we));
    check({tag, ".rd"}, 32'(wb_if.rd_out), 32'(rd));
    check({tag, ".wd"}, wb_if.wd_out, wd);
  endtask

  task automatic check_all_zero(input string tag);
    check_port(tag, 1'b0, 5'd0, 32'h0);
    check({tag, ".rdy"},  32'(wb_if.ll_ready_out), 32'd0);
    check({tag, ".busy"}, wb_if.busy_out, 32'h0);
    check({tag, ".err"},  32'(wb_if.protocol_err_out), 32'd0);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n_in = 1'b0;
    set_pipe(1'b0, 5'd0, 32'h0);
    set_ll(1'b0, 5'd0, 32'h0);
    set_issue(1'b0, 5'd0);

    // Reset state and release
    tick(); tick();
    check_all_zero("rst");
    rst_n_in = 1'b1;
    tick();
    check("rel.rdy", 32'(wb_if.ll_ready_out), 32'd1);
    check("rel.we",  32'(wb_if.write_enable_out), 32'd0);

    // Pipe only, then an x0 pipe write which must not enable and must hold rd/wd
    set_pipe(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    check_port("pipe5", 1'b1, 5'd5, 32'hDEADBEEF);
    set_pipe(1'b1, 5'd0, 32'h11111111);
    tick();
    check_port("pipe0", 1'b0, 5'd5, 32'hDEADBEEF);
    set_pipe(1'b0, 5'd0, 32'h0);

    // Long latency: issue x7, push, write one edge later
    set_issue(1'b1, 5'd7);
    tick();
    set_issue(1'b0, 5'd0);
    check("ll.busy7", wb_if.busy_out, 32'h0000_0080);
    set_ll(1'b1, 5'd7, 32'h1234);
    tick();
    check("ll.nobypass", 32'(wb_if.write_enable_out), 32'd0);
    set_ll(1'b0, 5'd0, 32'h0);
    tick();
    check_port("ll.pop7", 1'b1, 5'd7, 32'h1234);
    check("ll.busyclr", wb_if.busy_out, 32'h0);
    tick();
    check("ll.idle", 32'(wb_if.write_enable_out), 32'd0);

    // Contention: pipe x1..x4 while x8, x9 are pushed
    set_issue(1'b1, 5'd8); tick();
    set_issue(1'b1, 5'd9); tick();
    set_issue(1'b0, 5'd0);
    check("ct.busy", wb_if.busy_out, 32'h0000_0300);
    set_pipe(1'b1, 5'd1, 32'hA1); set_ll(1'b1, 5'd8, 32'h88);
    tick();
    check_port("ct.p1", 1'b1, 5'd1, 32'hA1);
    check("ct.rdy1", 32'(wb_if.ll_ready_out), 32'd1);
    set_pipe(1'b1, 5'd2, 32'hA2); set_ll(1'b1, 5'd9, 32'h99);
    tick();
    check_port("ct.p2", 1'b1, 5'd2, 32'hA2);
    check("ct.rdy2", 32'(wb_if.ll_ready_out), 32'd0);
    set_pipe(1'b1, 5'd3, 32'hA3); set_ll(1'b0, 5'd0, 32'h0);
    tick();
    check_port("ct.p3", 1'b1, 5'd3, 32'hA3);
    check("ct.busy3", wb_if.busy_out, 32'h0000_0300);
    set_pipe(1'b1, 5'd4, 32'hA4);
    tick();
    check_port("ct.p4", 1'b1, 5'd4, 32'hA4);
    set_pipe(1'b0, 5'd0, 32'h0);
    tick();
    check_port("ct.pop8", 1'b1, 5'd8, 32'h88);
    check("ct.busy8", wb_if.busy_out, 32'h0000_0200);
    check("ct.rdy3", 32'(wb_if.ll_ready_out), 32'd1);
    tick();
    check_port("ct.pop9", 1'b1, 5'd9, 32'h99);
    check("ct.busy9", wb_if.busy_out, 32'h0);
    tick();
    check("ct.idle", 32'(wb_if.write_enable_out), 32'd0);
    check("ct.noerr", 32'(wb_if.protocol_err_out), 32'd0);

    // Pop x3 and issue x3 in the same cycle: set wins
    set_issue(1'b1, 5'd3); tick();
    set_issue(1'b0, 5'd0);
    set_ll(1'b1, 5'd3, 32'h33); tick();
    set_ll(1'b0, 5'd0, 32'h0);
    set_issue(1'b1, 5'd3);
    tick();
    set_issue(1'b0, 5'd0);
    check_port("sc.pop3", 1'b1, 5'd3, 32'h33);
    check("sc.busy3", wb_if.busy_out, 32'h0000_0008);

    // Push and pop in one cycle at count 1 (depth-1)
    set_issue(1'b1, 5'd11); tick();
    set_issue(1'b1, 5'd12); tick();
    set_issue(1'b0, 5'd0);
    check("sc.busy", wb_if.busy_out, 32'h0000_1808);
    set_pipe(1'b1, 5'd1, 32'hB0); set_ll(1'b1, 5'd11, 32'hB1);
    tick();
    set_pipe(1'b0, 5'd0, 32'h0); set_ll(1'b1, 5'd12, 32'hC1);
    tick();
    set_ll(1'b0, 5'd0, 32'h0);
    check_port("sc.pp11", 1'b1, 5'd11, 32'hB1);
    check("sc.rdy", 32'(wb_if.ll_ready_out), 32'd1);
    check("sc.busyb", wb_if.busy_out, 32'h0000_1008);
    tick();
    check_port("sc.pop12", 1'b1, 5'd12, 32'hC1);
    check("sc.busyc", wb_if.busy_out, 32'h0000_0008);
    tick();
    check("sc.idle", 32'(wb_if.write_enable_out), 32'd0);
    check("sc.err", 32'(wb_if.protocol_err_out), 32'd1);

    // Reset mid-traffic: pending FIFO entry and busy state dropped
    set_issue(1'b1, 5'd13); tick();
    set_issue(1'b0, 5'd0);
    set_pipe(1'b1, 5'd2, 32'h22); set_ll(1'b1, 5'd13, 32'hD1);
    tick();
    check_port("mr.pre", 1'b1, 5'd2, 32'h22);
    rst_n_in = 1'b0;
    #2;
    check_all_zero("mr.async");
    for (int i = 0; i < 3; i++) tick();
    check_all_zero("mr.hold");
    set_pipe(1'b0, 5'd0, 32'h0); set_ll(1'b0, 5'd0, 32'h0);
    rst_n_in = 1'b1;
    tick();
    check("mr.rdy", 32'(wb_if.ll_ready_out), 32'd1);
    check("mr.we", 32'(wb_if.write_enable_out), 32'd0);
    tick();
    check("mr.empty", 32'(wb_if.write_enable_out), 32'd0);

    // Protocol error: double issue to x6, sticky until reset
    set_issue(1'b1, 5'd6); tick();
    check("pe.first", 32'(wb_if.protocol_err_out), 32'd0);
    check("pe.busy6", wb_if.busy_out, 32'h0000_0040);
    tick();
    set_issue(1'b0, 5'd0);
    check("pe.dbl", 32'(wb_if.protocol_err_out), 32'd1);
    tick(); tick();
    check("pe.sticky", 32'(wb_if.protocol_err_out), 32'd1);
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    tick();
    check("pe.clr", 32'(wb_if.protocol_err_out), 32'd0);

    // Protocol error: push to non-busy x10, write still proceeds
    set_ll(1'b1, 5'd10, 32'hAA);
    tick();
    set_ll(1'b0, 5'd0, 32'h0);
    check("pe.push", 32'(wb_if.protocol_err_out), 32'd1);
    tick();
    check_port("pe.wr10", 1'b1, 5'd10, 32'hAA);
    check("pe.hold", 32'(wb_if.protocol_err_out), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
